// File: rtl/ex_muldiv_pkg.sv
// Shared constants and state encoding for the RV32M multiply/divide unit.
package ex_muldiv_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and
// restoring divide sharing one 64-bit accumulator, with stall request.
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] op1_ex,
    input  logic [31:0] op2_ex,
    input  logic [31:0] ins,
    input  logic [4:0]  rd_addr2ex,
    input  logic        flush,
    output logic        hold_req,
    output logic        md_valid,
    output logic [31:0] md_result,
    output logic [4:0]  md_rd_addr
);

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opb_q, opb_d;
    logic [2:0]  f3_q, f3_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] res_q, res_d;
    logic [4:0]  mrd_q, mrd_d;

    logic        is_mop;
    logic [2:0]  f3_in;
    logic        s1_in, s2_in;
    logic [31:0] mag1, mag2;
    logic        div_zero, div_ovf;
    logic [31:0] special_res;
    logic [32:0] mul_sum;
    logic [32:0] rem_sh, diff;
    logic [63:0] step, prod;
    logic [31:0] quo, rem, final_res;
    logic        unused_ins;

    assign unused_ins = ^{ins[24:15], ins[11:7]};

    // Decode, operand magnitudes and division special cases from ID/EX.
    always_comb begin
        is_mop = (ins[6:0] == OPCODE_OP) && (ins[31:25] == FUNCT7_MULDIV);
        f3_in  = ins[14:12];
        if (f3_in[2]) begin
            s1_in = ~f3_in[0] & op1_ex[31];
            s2_in = ~f3_in[0] & op2_ex[31];
        end else begin
            s1_in = ((f3_in == F3_MULH) || (f3_in == F3_MULHSU)) & op1_ex[31];
            s2_in = (f3_in == F3_MULH) & op2_ex[31];
        end
        mag1     = s1_in ? -op1_ex : op1_ex;
        mag2     = s2_in ? -op2_ex : op2_ex;
        div_zero = f3_in[2] && (op2_ex == '0);
        div_ovf  = f3_in[2] && !f3_in[0] && (op1_ex == 32'h8000_0000) && (op2_ex == '1);
        if (div_zero)
            special_res = f3_in[1] ? op1_ex : '1;
        else
            special_res = f3_in[1] ? '0 : 32'h8000_0000;
    end

    // One iteration of the shared datapath, plus the sign fix-up of its output.
    always_comb begin
        mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        rem_sh  = {acc_q[63:32], acc_q[31]};
        diff    = rem_sh - {1'b0, opb_q};
        if (f3_q[2])
            step = diff[32] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                            : {diff[31:0], acc_q[30:0], 1'b1};
        else
            step = {mul_sum, acc_q[31:1]};
        prod = negq_q ? -step : step;
        quo  = negq_q ? -step[31:0] : step[31:0];
        rem  = negr_q ? -step[63:32] : step[63:32];
        case (f3_q)
            F3_MUL:             final_res = prod[31:0];
            F3_DIV, F3_DIVU:    final_res = quo;
            F3_REM, F3_REMU:    final_res = rem;
            default:            final_res = prod[63:32];
        endcase
    end

    // FSM next state, operand capture, iteration and result latching.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        f3_d    = f3_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        rd_d    = rd_q;
        res_d   = res_q;
        mrd_d   = mrd_q;
        case (state_q)
            ST_IDLE: begin
                if (is_mop && !flush) begin
                    f3_d   = f3_in;
                    rd_d   = rd_addr2ex;
                    negq_d = s1_in ^ s2_in;
                    negr_d = s1_in;
                    cnt_d  = '0;
                    if (div_zero || div_ovf) begin
                        res_d   = special_res;
                        mrd_d   = rd_addr2ex;
                        state_d = ST_DONE;
                    end else begin
                        acc_d   = {32'd0, mag1};
                        opb_d   = mag2;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                acc_d = step;
                if (cnt_q == 6'd31) begin
                    res_d   = final_res;
                    mrd_d   = rd_q;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            res_d   = res_q;
            mrd_d   = mrd_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            f3_q    <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            rd_q    <= '0;
            res_q   <= '0;
            mrd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            f3_q    <= f3_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
            mrd_q   <= mrd_d;
        end
    end

    assign hold_req   = rst && !flush &&
                        (((state_q == ST_IDLE) && is_mop) || (state_q == ST_CALC));
    assign md_valid   = (state_q == ST_DONE) && !flush;
    assign md_result  = res_q;
    assign md_rd_addr = mrd_q;

endmodule
